// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI-framed register bank fed by a byte-level SPI slave.
// One ssel-low frame is one transaction: a command byte (bit7 = write,
// bits[6:0] = start address) followed by data bytes that are written to or
// read from consecutive registers, with the pointer auto-incrementing.
// Optional feature: define SPI_REG_BANK_STATUS_EN to make address NUM_REGS-1
// a read-only view of status_in.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ssel                  raw chip select, active low
//   byte_rcvd, rx_data    received-byte pulse and byte from the slave
//   data_needed           slave sampling tx_data (informational only)
//   tx_data               next byte to shift out
//   regs_flat             register i on bits [8i+7:8i]
//   wr_strobe/addr/data   one-clk report of each accepted register write
//   rd_strobe             one-clk pulse per completed read data byte
//   status_in             status byte (SPI_REG_BANK_STATUS_EN only)
module spi_reg_bank #(
    parameter int          NUM_REGS  = 16,
    parameter logic [7:0]  REG_RESET = 8'h00,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ssel,
    input  logic                  byte_rcvd,
    input  logic [7:0]            rx_data,
    input  logic                  data_needed,
    output logic [7:0]            tx_data,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [6:0]            wr_addr,
    output logic [7:0]            wr_data,
    output logic                  rd_strobe,
    input  logic [7:0]            status_in
);
    localparam int         AW = $clog2(NUM_REGS);
    localparam logic [7:0] NR = 8'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

    state_t     state, state_nxt;
    logic [6:0] ptr;
    logic [7:0] regs [NUM_REGS];
    logic [7:0] rd_val;
    logic       in_range, ro, ld, we, unused;

    assign in_range = {1'b0, ptr} < NR;
    // ld marks every byte that advances the pointer; ssel high wins over byte_rcvd
    assign ld = !ssel && byte_rcvd && state != IDLE;
    assign we = ld && state == WRITE && in_range && !ro;
    assign tx_data = state == READ ? (in_range ? rd_val : 8'h00) : SYNC_BYTE;

`ifdef SPI_REG_BANK_STATUS_EN
    logic [7:0] stat_q;
    assign ro = {1'b0, ptr} == NR - 8'd1;
    assign rd_val = ro ? stat_q : regs[ptr[AW-1:0]];
    assign unused = data_needed;
    // status is captured together with the pointer so the byte is stable while it shifts
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) stat_q <= 8'h00;
        else if (ld) stat_q <= status_in;
`else
    assign ro = 1'b0;
    assign rd_val = regs[ptr[AW-1:0]];
    assign unused = ^{data_needed, status_in};
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        if (ssel) state_nxt = IDLE;
        else if (state == IDLE) state_nxt = CMD;
        else if (state == CMD && byte_rcvd) state_nxt = rx_data[7] ? WRITE : READ;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ptr       <= 7'd0;
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            wr_addr   <= 7'd0;
            wr_data   <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_RESET;
        end else begin
            wr_strobe <= we;
            rd_strobe <= ld && state == READ;
            if (ld) ptr <= state == CMD ? rx_data[6:0] : ptr + 7'd1;
            if (we) begin
                regs[ptr[AW-1:0]] <= rx_data;
                wr_addr           <= ptr;
                wr_data           <= rx_data;
            end
        end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs[g];
    end
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed self-checking bench for spi_reg_bank (NUM_REGS=16).
module tb_spi_reg_bank;
    logic         clk = 1'b0, rst_n = 1'b0, ssel = 1'b1, byte_rcvd = 1'b0, data_needed = 1'b0;
    logic [7:0]   rx_data = 8'h00, status_in = 8'h00;
    logic [7:0]   tx_data, wr_data;
    logic [127:0] regs_flat;
    logic         wr_strobe, rd_strobe;
    logic [6:0]   wr_addr;
    logic         ws, rs;
    logic [6:0]   wa;
    logic [7:0]   wd;
    int           ncmp = 0, nfail = 0;

`ifdef SPI_REG_BANK_STATUS_EN
    localparam bit ST = 1'b1;
`else
    localparam bit ST = 1'b0;
`endif

    spi_reg_bank dut (
        .clk(clk), .rst_n(rst_n), .ssel(ssel), .byte_rcvd(byte_rcvd), .rx_data(rx_data),
        .data_needed(data_needed), .tx_data(tx_data), .regs_flat(regs_flat),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_strobe(rd_strobe), .status_in(status_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        ncmp++;
        assert (o === e) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic logic [7:0] r(input int i);
        return regs_flat[8*i +: 8];
    endfunction

    task automatic send(input logic [7:0] b);
        rx_data = b;
        byte_rcvd = 1'b1;
        @(negedge clk);
        byte_rcvd = 1'b0;
        ws = wr_strobe; rs = rd_strobe; wa = wr_addr; wd = wr_data;
        @(negedge clk);
    endtask

    task automatic start();
        ssel = 1'b0;
        @(negedge clk);
    endtask

    task automatic stop();
        ssel = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_tx", tx_data, 8'hA5);
        chk("rst_regs", regs_flat, 128'h0);
        chk("rst_strobes", {wr_strobe, rd_strobe}, 2'b00);
        chk("rst_wr_addr_data", {wr_addr, wr_data}, 15'h0);
        rst_n = 1'b1;
        @(negedge clk);
        // write frame at address 2
        start();
        chk("cmd_tx", tx_data, 8'hA5);
        send(8'h82); chk("w_cmd_nostrobe", ws, 1'b0);
        send(8'h11); chk("w1_strobe", {ws, wa, wd}, {1'b1, 7'd2, 8'h11});
        send(8'h22); chk("w2_strobe", {ws, wa, wd}, {1'b1, 7'd3, 8'h22});
        chk("write_tx_sync", tx_data, 8'hA5);
        stop();
        chk("reg2_reg3", {r(3), r(2)}, 16'h2211);
        // read back from address 2
        start();
        chk("rd_tx0", tx_data, 8'hA5);
        send(8'h02); chk("rd_tx1", tx_data, 8'h11); chk("rd_cmd_nostrobe", rs, 1'b0);
        send(8'h00); chk("rd_tx2", {rs, tx_data}, {1'b1, 8'h22});
        send(8'h00); chk("rd_tx3", {rs, tx_data}, {1'b1, 8'h00});
        send(8'h00); chk("rd_strobe3", rs, 1'b1);
        stop();
        chk("idle_tx", tx_data, 8'hA5);
        // write past the top of the bank
        start();
        send(8'h8F);
        send(8'hAA); chk("w15_strobe", ws, !ST);
        send(8'hBB); chk("w16_dropped", ws, 1'b0);
        stop();
        chk("reg15", r(15), ST ? 8'h00 : 8'hAA);
        chk("reg0_untouched", r(0), 8'h00);
        start(); send(8'h80); send(8'h5C); stop();
        // read from 127 wraps to 0
        start();
        send(8'h7F); chk("rd127", tx_data, 8'h00);
        send(8'h00); chk("rd_wrap0", {rs, tx_data}, {1'b1, 8'h5C});
        send(8'h00); chk("rd_wrap1", tx_data, 8'h00);
        stop();
        // abort mid-byte, then byte_rcvd while idle
        start();
        send(8'h85);
        ssel = 1'b1;
        @(negedge clk);
        chk("abort_tx", tx_data, 8'hA5);
        rx_data = 8'h83; byte_rcvd = 1'b1;
        @(negedge clk);
        byte_rcvd = 1'b0;
        chk("idle_byte_ignored", {wr_strobe, rd_strobe}, 2'b00);
        // ssel high wins over a simultaneous byte_rcvd
        start();
        send(8'h85);
        ssel = 1'b1; rx_data = 8'h5A; byte_rcvd = 1'b1;
        @(negedge clk);
        byte_rcvd = 1'b0;
        chk("prio_nostrobe", wr_strobe, 1'b0);
        chk("reg5_unchanged", r(5), 8'h00);
        start();
        chk("clean_cmd_tx", tx_data, 8'hA5);
        send(8'h03); chk("clean_rd3", tx_data, 8'h22);
        stop();
        // status address behaviour
        status_in = 8'h3C;
        start(); send(8'h8F); send(8'h99); chk("status_w_strobe", ws, !ST); stop();
        chk("status_reg15", r(15), ST ? 8'h00 : 8'h99);
        start(); send(8'h0F); chk("status_rd", tx_data, ST ? 8'h3C : 8'h99); stop();
        // asynchronous reset mid-frame
        start(); send(8'h81); send(8'h77);
        chk("reg1_written", r(1), 8'h77);
        rst_n = 1'b0;
        #1;
        chk("async_rst_regs", regs_flat, 128'h0);
        chk("async_rst_tx", tx_data, 8'hA5);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h02); chk("post_rst_rd2", tx_data, 8'h00);
        stop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
